// File: rtl/bram_dp_param_clr.sv
// Purpose: true dual-port RAM with per-bit write mask, selectable read-during-write and a hardware clear engine.
// Latency: read data on Qx 1 cycle after CEx (2 cycles with OUT_REG = 1); clear pass takes DEPTH cycles.
// Backpressure: none on the ports; while BUSY = 1 the clear engine owns the array and user CE0/CE1 are ignored.
//
// Ports:
//   CLK, RST            clock (rising edge) and asynchronous active-high reset
//   A0/D0/WE0/WEM0/CE0  port 0 address, write data, write enable, per-bit write mask, port enable
//   Q0                  port 0 read data
//   A1/D1/WE1/WEM1/CE1  port 1, same as port 0
//   Q1                  port 1 read data
//   CLR                 request a new clear pass (ignored while one is running)
//   BUSY                clear engine owns the array

module bram_dp_param_clr #(
    parameter int              WIDTH      = 8,
    parameter int              DEPTH      = 1024,
    parameter int              AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int              WRITE_MODE = 0,
    parameter int              OUT_REG    = 0,
    parameter logic [WIDTH-1:0] INIT_VAL  = {WIDTH{1'b0}}
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [AW-1:0]    A0,
    input  logic [WIDTH-1:0] D0,
    output logic [WIDTH-1:0] Q0,
    input  logic             WE0,
    input  logic [WIDTH-1:0] WEM0,
    input  logic             CE0,
    input  logic [AW-1:0]    A1,
    input  logic [WIDTH-1:0] D1,
    output logic [WIDTH-1:0] Q1,
    input  logic             WE1,
    input  logic [WIDTH-1:0] WEM1,
    input  logic             CE1,
    input  logic             CLR,
    output logic             BUSY
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];

    state_t           state_q;
    logic [AW-1:0]    cnt_q;
    logic             busy_q;

    logic             ce0_g, ce1_g;
    logic             a0_ok, a1_ok;
    logic             wr0, wr1;
    logic [WIDTH-1:0] old0, old1;
    logic [WIDTH-1:0] rd0_d, rd1_d;

    logic [WIDTH-1:0] r0_q, r1_q;
    logic             v0_q, v1_q;
    logic [WIDTH-1:0] o0_q, o1_q;

    // Clear engine: one INIT_VAL word per cycle; BUSY is a registered copy of the state.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                S_CLEAR: begin
                    if (cnt_q == LAST) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + AW'(1);
                    end
                end
                default: begin
                    if (CLR) begin
                        state_q <= S_CLEAR;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        ce0_g = CE0 & ~busy_q;
        ce1_g = CE1 & ~busy_q;
        a0_ok = ({1'b0, A0} < DEPTH_W);
        a1_ok = ({1'b0, A1} < DEPTH_W);
        wr0   = ce0_g & WE0 & a0_ok;
        wr1   = ce1_g & WE1 & a1_ok;
        old0  = a0_ok ? mem[A0] : '0;
        old1  = a1_ok ? mem[A1] : '0;
        // Write-first only looks at the port's own write; the other port's write is never forwarded.
        rd0_d = old0;
        rd1_d = old1;
        if (WRITE_MODE == 1 && wr0) rd0_d = (old0 & ~WEM0) | (D0 & WEM0);
        if (WRITE_MODE == 1 && wr1) rd1_d = (old1 & ~WEM1) | (D1 & WEM1);
    end

    // Array write. Same-address dual writes are merged into one update so that bits
    // masked only by port 1 survive while port 0 wins on overlapping bits.
    always_ff @(posedge CLK) begin
        if (state_q == S_CLEAR) begin
            mem[cnt_q] <= INIT_VAL;
        end else if (wr0 && wr1 && (A0 == A1)) begin
            mem[A0] <= (mem[A0] & ~(WEM0 | WEM1)) | (D1 & WEM1 & ~WEM0) | (D0 & WEM0);
        end else begin
            if (wr0) mem[A0] <= (mem[A0] & ~WEM0) | (D0 & WEM0);
            if (wr1) mem[A1] <= (mem[A1] & ~WEM1) | (D1 & WEM1);
        end
    end

    // Read pipeline. The output register only loads when the stage before it took a
    // read on the previous cycle, so both stages hold while the port is idle or busy.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r0_q <= '0;
            r1_q <= '0;
            v0_q <= 1'b0;
            v1_q <= 1'b0;
            o0_q <= '0;
            o1_q <= '0;
        end else begin
            if (ce0_g) r0_q <= rd0_d;
            if (ce1_g) r1_q <= rd1_d;
            v0_q <= ce0_g;
            v1_q <= ce1_g;
            if (v0_q) o0_q <= r0_q;
            if (v1_q) o1_q <= r1_q;
        end
    end

    assign Q0   = (OUT_REG != 0) ? o0_q : r0_q;
    assign Q1   = (OUT_REG != 0) ? o1_q : r1_q;
    assign BUSY = busy_q;

endmodule

// File: tb/tb_bram_dp_param_clr.sv
// Purpose: exercises two configurations of bram_dp_param_clr against an array-based model.
// Latency: DUT a is DEPTH 1024 read-first latency 1; DUT b is DEPTH 1000 write-first latency 2.
// Backpressure: none; both DUTs see identical port stimulus every cycle.

module tb_bram_dp_param_clr;

    localparam logic [7:0] IV = 8'hA5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [9:0] a0, a1;
    logic [7:0] d0, d1, wem0, wem1;
    logic       we0, we1, ce0, ce1, clr;
    logic [7:0] qa0, qa1, qb0, qb1;
    logic       busy_a, busy_b;

    bram_dp_param_clr #(.WIDTH(8), .DEPTH(1024), .WRITE_MODE(0), .OUT_REG(0), .INIT_VAL(8'hA5)) u_a (
        .CLK(clk), .RST(rst),
        .A0(a0), .D0(d0), .Q0(qa0), .WE0(we0), .WEM0(wem0), .CE0(ce0),
        .A1(a1), .D1(d1), .Q1(qa1), .WE1(we1), .WEM1(wem1), .CE1(ce1),
        .CLR(clr), .BUSY(busy_a)
    );

    bram_dp_param_clr #(.WIDTH(8), .DEPTH(1000), .WRITE_MODE(1), .OUT_REG(1), .INIT_VAL(8'hA5)) u_b (
        .CLK(clk), .RST(rst),
        .A0(a0), .D0(d0), .Q0(qb0), .WE0(we0), .WEM0(wem0), .CE0(ce0),
        .A1(a1), .D1(d1), .Q1(qb1), .WE1(we1), .WEM1(wem1), .CE1(ce1),
        .CLR(clr), .BUSY(busy_b)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Model state per DUT: contents, clear progress, visible outputs and a short delay line.
    logic [7:0] mm [2][1024];
    int         busy_left [2];
    int         clr_ptr [2];
    logic [7:0] exp_q [2][2];
    logic       sl_v [2][2][2];
    logic [7:0] sl_d [2][2][2];

    function automatic int dep(input int k);
        return (k == 0) ? 1024 : 1000;
    endfunction

    function automatic int lat(input int k);
        return (k == 0) ? 1 : 2;
    endfunction

    function automatic int wmode(input int k);
        return (k == 0) ? 0 : 1;
    endfunction

    function automatic logic [7:0] dq(input int k, input int p);
        if (k == 0) return (p == 0) ? qa0 : qa1;
        return (p == 0) ? qb0 : qb1;
    endfunction

    function automatic logic dbusy(input int k);
        return (k == 0) ? busy_a : busy_b;
    endfunction

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s dut%0d: got %0h, expected %0h at %0t", nm, k, act, exp, $time);
        end
    endtask

    task automatic model_reset(input int k);
        busy_left[k] = dep(k);
        clr_ptr[k]   = 0;
        for (int p = 0; p < 2; p++) begin
            exp_q[k][p] = 8'h00;
            for (int s = 0; s < 2; s++) begin
                sl_v[k][p][s] = 1'b0;
                sl_d[k][p][s] = 8'h00;
            end
        end
    endtask

    // One clock edge of the memory as seen from the outside.
    task automatic model_step(input int k);
        logic [9:0] ad [2];
        logic [7:0] dd [2];
        logic [7:0] mk [2];
        logic       ce [2];
        logic       we [2];
        logic       rd [2];
        logic [7:0] rdv [2];
        ad[0] = a0;  ad[1] = a1;
        dd[0] = d0;  dd[1] = d1;
        mk[0] = wem0; mk[1] = wem1;
        ce[0] = ce0; ce[1] = ce1;
        we[0] = we0; we[1] = we1;
        if (rst) begin
            model_reset(k);
            return;
        end
        for (int p = 0; p < 2; p++) begin
            rd[p]  = 1'b0;
            rdv[p] = 8'h00;
        end
        if (busy_left[k] > 0) begin
            mm[k][10'(clr_ptr[k])] = IV;
            clr_ptr[k]++;
            busy_left[k]--;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (ce[p]) begin
                    rd[p]  = 1'b1;
                    rdv[p] = (int'(ad[p]) < dep(k)) ? mm[k][ad[p]] : 8'h00;
                    if (wmode(k) == 1 && we[p] && int'(ad[p]) < dep(k))
                        rdv[p] = (rdv[p] & ~mk[p]) | (dd[p] & mk[p]);
                end
            end
            // Port 1 applied first, so port 0 overrides on shared mask bits.
            for (int p = 1; p >= 0; p--) begin
                if (ce[p] && we[p] && int'(ad[p]) < dep(k))
                    mm[k][ad[p]] = (mm[k][ad[p]] & ~mk[p]) | (dd[p] & mk[p]);
            end
            if (clr) begin
                busy_left[k] = dep(k);
                clr_ptr[k]   = 0;
            end
        end
        for (int p = 0; p < 2; p++) begin
            sl_v[k][p][lat(k)-1] = rd[p];
            sl_d[k][p][lat(k)-1] = rdv[p];
            if (sl_v[k][p][0]) exp_q[k][p] = sl_d[k][p][0];
            sl_v[k][p][0] = sl_v[k][p][1];
            sl_d[k][p][0] = sl_d[k][p][1];
            sl_v[k][p][1] = 1'b0;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            model_step(k);
            chk("busy", k, 32'(dbusy(k)), 32'(busy_left[k] > 0));
            chk("q0",   k, 32'(dq(k, 0)), 32'(exp_q[k][0]));
            chk("q1",   k, 32'(dq(k, 1)), 32'(exp_q[k][1]));
        end
    endtask

    task automatic idle();
        a0 = '0; a1 = '0; d0 = '0; d1 = '0; wem0 = '0; wem1 = '0;
        we0 = 1'b0; we1 = 1'b0; ce0 = 1'b0; ce1 = 1'b0; clr = 1'b0;
    endtask

    // Runs until both BUSY outputs fall, returning the cycle index of each fall.
    // With inject set, a write to address 3 and a second CLR are issued mid-pass.
    task automatic run_clear(input bit inject, output int fa, output int fb);
        fa = -1;
        fb = -1;
        for (int n = 1; n <= 1100; n++) begin
            idle();
            if (inject && n == 10) begin
                a0 = 10'd3; d0 = 8'h5A; wem0 = 8'hFF; we0 = 1'b1; ce0 = 1'b1;
                a1 = 10'd3; ce1 = 1'b1;
            end
            if (inject && n == 300) clr = 1'b1;
            cyc();
            if (fa < 0 && !busy_a) fa = n;
            if (fb < 0 && !busy_b) fb = n;
            if (fa >= 0 && fb >= 0) break;
        end
        idle();
    endtask

    task automatic sweep();
        for (int i = 0; i < 1024; i++) begin
            a0 = 10'(i); a1 = 10'(1023 - i); ce0 = 1'b1; ce1 = 1'b1;
            cyc();
        end
        idle();
        cyc();
        cyc();
    endtask

    int fa, fb;

    initial begin
        idle();
        rst = 1'b1;
        model_reset(0);
        model_reset(1);
        repeat (3) cyc();
        chk("rst_busy", 0, 32'(busy_a), 32'd1);
        chk("rst_busy", 1, 32'(busy_b), 32'd1);
        chk("rst_q0",   1, 32'(qb0),    32'd0);

        // Power-up clear
        rst = 1'b0;
        run_clear(1'b0, fa, fb);
        chk("clear_len", 0, 32'(fa), 32'd1024);
        chk("clear_len", 1, 32'(fb), 32'd1000);
        sweep();

        // Masked write then read on the other port
        a0 = 10'd5; d0 = 8'hFF; wem0 = 8'h0F; we0 = 1'b1; ce0 = 1'b1;
        cyc(); idle();
        a1 = 10'd5; ce1 = 1'b1;
        cyc(); idle(); cyc(); cyc();
        chk("masked", 0, 32'(qa1), 32'hAF);
        chk("masked", 1, 32'(qb1), 32'hAF);

        // Read-during-write, same port and cross port
        a0 = 10'd7; d0 = 8'h11; wem0 = 8'hFF; we0 = 1'b1; ce0 = 1'b1;
        cyc();
        a0 = 10'd7; d0 = 8'h22; wem0 = 8'hFF; we0 = 1'b1; ce0 = 1'b1;
        a1 = 10'd7; ce1 = 1'b1;
        cyc(); idle(); cyc(); cyc();
        chk("rdw_q0", 0, 32'(qa0), 32'h11);
        chk("rdw_q0", 1, 32'(qb0), 32'h22);
        chk("rdw_q1", 0, 32'(qa1), 32'h11);
        chk("rdw_q1", 1, 32'(qb1), 32'h11);

        // Dual-write collision, full masks then disjoint masks
        for (int r = 0; r < 2; r++) begin
            a0 = 10'd9; d0 = 8'hF0; wem0 = (r == 0) ? 8'hFF : 8'hF0; we0 = 1'b1; ce0 = 1'b1;
            a1 = 10'd9; d1 = 8'h0F; wem1 = (r == 0) ? 8'hFF : 8'h0F; we1 = 1'b1; ce1 = 1'b1;
            cyc(); idle();
            a0 = 10'd9; ce0 = 1'b1;
            cyc(); idle(); cyc(); cyc();
            chk("collide", 0, 32'(qa0), (r == 0) ? 32'hF0 : 32'hFF);
            chk("collide", 1, 32'(qb0), (r == 0) ? 32'hF0 : 32'hFF);
        end

        // Boundary: address 1000 is past the end of DUT b only
        a0 = 10'd1000; d0 = 8'h3C; wem0 = 8'hFF; we0 = 1'b1; ce0 = 1'b1;
        cyc(); idle();
        a0 = 10'd1000; ce0 = 1'b1; a1 = 10'd999; ce1 = 1'b1;
        cyc(); idle(); cyc(); cyc();
        chk("oob_rd",  0, 32'(qa0), 32'h3C);
        chk("oob_rd",  1, 32'(qb0), 32'h00);
        chk("last_rd", 0, 32'(qa1), 32'hA5);
        chk("last_rd", 1, 32'(qb1), 32'hA5);

        // Random traffic on a small address window plus the top edge
        for (int n = 0; n < 3000; n++) begin
            a0 = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(990, 1023)) : 10'($urandom_range(0, 15));
            a1 = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(990, 1023)) : 10'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) a1 = a0;
            d0 = 8'($urandom); d1 = 8'($urandom);
            wem0 = 8'($urandom); wem1 = 8'($urandom);
            we0 = 1'($urandom_range(0, 1)); we1 = 1'($urandom_range(0, 1));
            ce0 = 1'($urandom_range(0, 1)); ce1 = 1'($urandom_range(0, 1));
            clr = ($urandom_range(0, 499) == 0);
            cyc();
        end
        idle();
        for (int n = 0; n < 2100 && (busy_a || busy_b); n++) cyc();

        // Re-clear with a blocked write and an ignored second CLR
        a0 = 10'd3; d0 = 8'h3C; wem0 = 8'hFF; we0 = 1'b1; ce0 = 1'b1;
        cyc(); idle();
        clr = 1'b1;
        cyc(); idle();
        chk("reclr_busy", 0, 32'(busy_a), 32'd1);
        run_clear(1'b1, fa, fb);
        chk("reclr_len", 0, 32'(fa), 32'd1024);
        chk("reclr_len", 1, 32'(fb), 32'd1000);
        a0 = 10'd3; ce0 = 1'b1;
        cyc(); idle(); cyc(); cyc();
        chk("reclr_a3", 0, 32'(qa0), 32'hA5);
        chk("reclr_a3", 1, 32'(qb0), 32'hA5);
        sweep();

        // Reset in the middle of a clear pass
        a0 = 10'd5; d0 = 8'h77; wem0 = 8'hFF; we0 = 1'b1; ce0 = 1'b1;
        cyc(); idle();
        a0 = 10'd5; ce0 = 1'b1; a1 = 10'd5; ce1 = 1'b1;
        cyc(); idle(); cyc(); cyc();
        chk("pre_rst_q0", 1, 32'(qb0), 32'h77);
        clr = 1'b1;
        cyc(); idle();
        repeat (499) cyc();
        rst = 1'b1;
        #1;
        chk("mid_rst_q0",   0, 32'(qa0),    32'd0);
        chk("mid_rst_q1",   0, 32'(qa1),    32'd0);
        chk("mid_rst_q0",   1, 32'(qb0),    32'd0);
        chk("mid_rst_q1",   1, 32'(qb1),    32'd0);
        chk("mid_rst_busy", 0, 32'(busy_a), 32'd1);
        chk("mid_rst_busy", 1, 32'(busy_b), 32'd1);
        model_reset(0);
        model_reset(1);
        cyc(); cyc();
        rst = 1'b0;
        run_clear(1'b0, fa, fb);
        chk("rst_clear_len", 0, 32'(fa), 32'd1024);
        chk("rst_clear_len", 1, 32'(fb), 32'd1000);
        sweep();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
